// File: rtl/axi4_rd_outstanding_ctrl_pkg.sv
// ============================================================================
// Module  : axi4_partition_pkg
// Brief   : Shared widths, types and helpers for the read-partition slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_partition_pkg;

  localparam int unsigned c_lsize_def = 8;

  // One recorded arlen per in-flight burst.
  typedef logic [c_lsize_def-1:0] len_entry_t;

  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_rd_outstanding_ctrl_if.sv
// ============================================================================
// Module  : axi_inf
// Brief   : AXI4 read-address and read-data channels with rd-only modports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_inf
  import axi4_partition_pkg::*;
#(
  parameter int unsigned IDSIZE = 4,
  parameter int unsigned ASIZE  = 32,
  parameter int unsigned LSIZE  = c_lsize_def,
  parameter int unsigned DSIZE  = 32
)(
  input logic axi_aclk
);

  logic [IDSIZE-1:0] arid;
  logic [ASIZE-1:0]  araddr;
  logic [LSIZE-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [IDSIZE-1:0] rid;
  logic [DSIZE-1:0]  rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master_rd (
    input  axi_aclk,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slaver_rd (
    input  axi_aclk,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

`default_nettype wire

// File: rtl/axi4_rd_len_fifo.sv
// ============================================================================
// Module  : axi4_rd_len_fifo
// Brief   : Show-ahead synchronous FIFO holding issued burst lengths.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_rd_len_fifo
  import axi4_partition_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DSIZE = $bits(len_entry_t)
)(
  input  logic             clock,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             wr_en,
  output logic [DSIZE-1:0] rdata,
  input  logic             rd_en,
  output logic             empty,
  output logic             full
);

  localparam int unsigned      c_iw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_iw-1:0]  c_last_idx = c_iw'(DEPTH - 1);

  logic [c_iw:0]     r_wr_ptr;
  logic [c_iw:0]     r_rd_ptr;
  logic [DSIZE-1:0]  r_mem [DEPTH];
  logic              w_wr_fire;
  logic              w_rd_fire;

  // Index wraps explicitly at DEPTH-1 and toggles the wrap bit, so any depth works.
  function automatic logic [c_iw:0] f_next_ptr(input logic [c_iw:0] ptr);
    if (ptr[c_iw-1:0] == c_last_idx) begin
      return {~ptr[c_iw], {c_iw{1'b0}}};
    end
    return {ptr[c_iw], ptr[c_iw-1:0] + 1'b1};
  endfunction

  assign w_wr_fire = wr_en & ~full;
  assign w_rd_fire = rd_en & ~empty;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_rd_fire) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[c_iw-1:0]] <= wdata;
    end
  end

  assign rdata = r_mem[r_rd_ptr[c_iw-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_iw-1:0] == r_rd_ptr[c_iw-1:0]) &
                 (r_wr_ptr[c_iw] != r_rd_ptr[c_iw]);

endmodule

`default_nettype wire

// File: rtl/axi4_rd_outstanding_ctrl.sv
// ============================================================================
// Module  : axi4_rd_outstanding_ctrl
// Brief   : Caps outstanding AR bursts and regenerates rlast from issued arlen.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_rd_outstanding_ctrl
  import axi4_partition_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned LSIZE     = c_lsize_def
)(
  input  logic                           clock,
  input  logic                           rst_n,
  axi_inf.slaver_rd                      up_inf,
  axi_inf.master_rd                      down_inf,
  output logic [clog2p1(MAX_OUTST)-1:0]  outst_cnt,
  output logic                           len_err,
  output logic                           idle
);

  localparam int unsigned         c_cnt_w   = clog2p1(MAX_OUTST);
  localparam logic [c_cnt_w-1:0]  c_max_cnt = c_cnt_w'(MAX_OUTST);

  logic [c_cnt_w-1:0] r_outst_cnt;
  logic [LSIZE:0]     r_beat_cnt;
  logic               r_len_err;

  logic               w_full;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [LSIZE-1:0]   w_head_len;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_exp_last;
  logic               w_pop;
  logic               w_err;

  // The FIFO is sized to MAX_OUTST, so both full terms agree; the OR is defensive.
  assign w_full = (r_outst_cnt == c_max_cnt) | w_fifo_full;

  assign down_inf.arvalid = up_inf.arvalid & ~w_full;
  assign up_inf.arready   = down_inf.arready & ~w_full;
  assign down_inf.arid    = up_inf.arid;
  assign down_inf.araddr  = up_inf.araddr;
  assign down_inf.arlen   = up_inf.arlen;
  assign down_inf.arsize  = up_inf.arsize;
  assign down_inf.arburst = up_inf.arburst;
  assign down_inf.arlock  = up_inf.arlock;
  assign down_inf.arcache = up_inf.arcache;
  assign down_inf.arprot  = up_inf.arprot;
  assign down_inf.arqos   = up_inf.arqos;

  assign up_inf.rid       = down_inf.rid;
  assign up_inf.rdata     = down_inf.rdata;
  assign up_inf.rresp     = down_inf.rresp;
  assign up_inf.rvalid    = down_inf.rvalid;
  assign down_inf.rready  = up_inf.rready;
  assign up_inf.rlast     = w_exp_last;

  assign w_ar_hs    = down_inf.arvalid & down_inf.arready;
  assign w_r_hs     = down_inf.rvalid & down_inf.rready;
  assign w_exp_last = ~w_fifo_empty & (r_beat_cnt == {1'b0, w_head_len});
  assign w_pop      = w_r_hs & w_exp_last;
  // An orphan beat (nothing recorded) is always an error regardless of its rlast.
  assign w_err      = w_r_hs & (w_fifo_empty | (down_inf.rlast != w_exp_last));

  axi4_rd_len_fifo #(
    .DEPTH (MAX_OUTST),
    .DSIZE (LSIZE)
  ) u_len_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .wdata (down_inf.arlen),
    .wr_en (w_ar_hs),
    .rdata (w_head_len),
    .rd_en (w_pop),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_outst_cnt <= '0;
    end else begin
      unique case ({w_ar_hs, w_pop})
        2'b10:   r_outst_cnt <= r_outst_cnt + 1'b1;
        2'b01:   r_outst_cnt <= r_outst_cnt - 1'b1;
        default: r_outst_cnt <= r_outst_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_r_hs && !w_fifo_empty) begin
      if (w_exp_last) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_err;
    end
  end

  assign outst_cnt = r_outst_cnt;
  assign len_err   = r_len_err;
  assign idle      = (r_outst_cnt == '0) & ~down_inf.rvalid;

endmodule

`default_nettype wire

// File: tb/tb_axi4_rd_outstanding_ctrl.sv
// ============================================================================
// Module  : tb_axi4_rd_outstanding_ctrl
// Brief   : Directed scoreboard bench for the outstanding-read controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_rd_outstanding_ctrl;
  import axi4_partition_pkg::*;

  logic       clock;
  logic       rst_n;
  logic [3:0] outst_cnt;
  logic       len_err;
  logic       idle;

  axi_inf up_if   (.axi_aclk(clock));
  axi_inf down_if (.axi_aclk(clock));

  axi4_rd_outstanding_ctrl #(
    .MAX_OUTST (8),
    .LSIZE     (8)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .up_inf    (up_if),
    .down_inf  (down_if),
    .outst_cnt (outst_cnt),
    .len_err   (len_err),
    .idle      (idle)
  );

  typedef struct packed {
    logic [31:0] addr;
    len_entry_t  len;
  } ar_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t mon_ar;
  r_exp_t  mon_r;
  int      vectors = 0;
  int      miscompares = 0;
  logic    err_pend_v = 1'b0;
  logic    err_pend = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever a handshake is presented.
  always @(negedge clock) begin
    if (!rst_n) begin
      err_pend_v = 1'b0;
    end else begin
      if (err_pend_v) check("len_err", len_err, err_pend);
      else if (len_err) check("len_err_spurious", len_err, 0);
      err_pend_v = 1'b0;
      if (down_if.arvalid && down_if.arready) begin
        if (ar_q.size() == 0) begin
          check("ar_unexpected", 1, 0);
        end else begin
          mon_ar = ar_q.pop_front();
          check("arlen", down_if.arlen, mon_ar.len);
          check("araddr", down_if.araddr, mon_ar.addr);
        end
      end
      if (up_if.rvalid && up_if.rready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 1, 0);
        end else begin
          mon_r = r_q.pop_front();
          check("rdata", up_if.rdata, mon_r.data);
          check("rlast", up_if.rlast, mon_r.last);
          err_pend_v = 1'b1;
          err_pend   = mon_r.err;
        end
      end
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic ar_send(input logic [7:0] len, input logic [31:0] addr);
    up_if.arvalid = 1'b1;
    up_if.arlen   = len;
    up_if.araddr  = addr;
    ar_q.push_back('{addr: addr, len: len});
    for (int n = 0; ; n++) begin
      @(negedge clock);
      if (up_if.arvalid && up_if.arready) break;
      if (n == 1000) begin
        check("ar_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock); #1;
    up_if.arvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic last,
                        input logic exp_last, input logic exp_err);
    down_if.rvalid = 1'b1;
    down_if.rdata  = data;
    down_if.rlast  = last;
    r_q.push_back('{data: data, last: exp_last, err: exp_err});
    for (int n = 0; ; n++) begin
      @(negedge clock);
      if (down_if.rvalid && down_if.rready) break;
      if (n == 1000) begin
        check("r_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock); #1;
    down_if.rvalid = 1'b0;
    down_if.rlast  = 1'b0;
  endtask

  task automatic burst_beats(input int len, input logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      r_beat(base + 32'(i), (i == len), (i == len), 1'b0);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] exp);
    @(negedge clock);
    check(name, outst_cnt, exp);
    @(posedge clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    up_if.arvalid   = 1'b0;
    up_if.arid      = 4'h3;
    up_if.araddr    = '0;
    up_if.arlen     = '0;
    up_if.arsize    = 3'd2;
    up_if.arburst   = 2'b01;
    up_if.arlock    = 1'b0;
    up_if.arcache   = 4'h3;
    up_if.arprot    = 3'd0;
    up_if.arqos     = 4'd0;
    up_if.rready    = 1'b1;
    down_if.arready = 1'b1;
    down_if.rvalid  = 1'b0;
    down_if.rid     = 4'h3;
    down_if.rdata   = '0;
    down_if.rresp   = 2'b00;
    down_if.rlast   = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_outst_cnt", outst_cnt, 0);
    check("rst_len_err", len_err, 0);
    check("rst_idle", idle, 1);
    check("rst_arready", up_if.arready, 1);
    @(posedge clock); #1;

    // 1: single arlen=3 burst
    ar_send(8'd3, 32'h1000);
    chk_cnt("t1_cnt_after_ar", 4'd1);
    burst_beats(3, 32'hA000);
    chk_cnt("t1_cnt_done", 4'd0);

    // 2: saturate at 8 outstanding, then release one slot at a time
    for (int i = 0; i < 8; i++) ar_send(8'd0, 32'h2000 + 32'(i * 64));
    chk_cnt("t2_cnt_full", 4'd8);
    up_if.arvalid = 1'b1;
    up_if.arlen   = 8'd0;
    up_if.araddr  = 32'h2200;
    ar_q.push_back('{addr: 32'h2200, len: 8'd0});
    @(negedge clock);
    check("t2_arready_full", up_if.arready, 0);
    check("t2_down_arvalid_masked", down_if.arvalid, 0);
    @(posedge clock); #1;
    r_beat(32'hB000, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    check("t2_arready_after_pop", up_if.arready, 1);
    check("t2_cnt_after_pop", outst_cnt, 7);
    @(posedge clock); #1;
    up_if.araddr = 32'h2240;
    ar_q.push_back('{addr: 32'h2240, len: 8'd0});
    @(negedge clock);
    check("t2_arready_refull", up_if.arready, 0);
    check("t2_cnt_refull", outst_cnt, 8);
    @(posedge clock); #1;
    r_beat(32'hB001, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    check("t2_arready_10th", up_if.arready, 1);
    @(posedge clock); #1;
    up_if.arvalid = 1'b0;
    for (int i = 0; i < 8; i++) r_beat(32'hB100 + 32'(i), 1'b1, 1'b1, 1'b0);
    chk_cnt("t2_cnt_drained", 4'd0);

    // 3: concurrent AR push and last-R pop at outst_cnt=4
    ar_send(8'd2, 32'h3000);
    ar_send(8'd0, 32'h3100);
    ar_send(8'd7, 32'h3200);
    ar_send(8'd1, 32'h3300);
    chk_cnt("t3_cnt4", 4'd4);
    r_beat(32'hC000, 1'b0, 1'b0, 1'b0);
    r_beat(32'hC001, 1'b0, 1'b0, 1'b0);
    up_if.arvalid  = 1'b1;
    up_if.arlen    = 8'd255;
    up_if.araddr   = 32'h3400;
    ar_q.push_back('{addr: 32'h3400, len: 8'd255});
    down_if.rvalid = 1'b1;
    down_if.rdata  = 32'hC002;
    down_if.rlast  = 1'b1;
    r_q.push_back('{data: 32'hC002, last: 1'b1, err: 1'b0});
    @(negedge clock);
    check("t3_ar_concurrent", up_if.arready, 1);
    @(posedge clock); #1;
    up_if.arvalid  = 1'b0;
    down_if.rvalid = 1'b0;
    down_if.rlast  = 1'b0;
    chk_cnt("t3_cnt_still4", 4'd4);
    burst_beats(0, 32'hD000);
    chk_cnt("t3_cnt3", 4'd3);
    burst_beats(7, 32'hD100);
    chk_cnt("t3_cnt2", 4'd2);
    burst_beats(1, 32'hD200);
    chk_cnt("t3_cnt1", 4'd1);
    burst_beats(255, 32'hD300);
    chk_cnt("t3_cnt0", 4'd0);

    // 4: slave raises rlast early on beat 2 of an arlen=5 burst
    ar_send(8'd5, 32'h4000);
    for (int i = 0; i <= 5; i++) begin
      r_beat(32'hE000 + 32'(i), (i == 2 || i == 5), (i == 5), (i == 2));
    end
    chk_cnt("t4_cnt0", 4'd0);

    // 5: orphan R beat
    r_beat(32'hF000, 1'b0, 1'b0, 1'b1);
    chk_cnt("t5_cnt0", 4'd0);

    // 6: reset mid-burst with three bursts outstanding
    ar_send(8'd3, 32'h6000);
    ar_send(8'd3, 32'h6100);
    ar_send(8'd3, 32'h6200);
    r_beat(32'h6A00, 1'b0, 1'b0, 1'b0);
    chk_cnt("t6_cnt3", 4'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", outst_cnt, 0);
    check("t6_rst_idle", idle, 1);
    check("t6_rst_len_err", len_err, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    ar_send(8'd0, 32'h6300);
    r_beat(32'h6B00, 1'b1, 1'b1, 1'b0);
    chk_cnt("t6_cnt0", 4'd0);
    @(negedge clock);
    check("t6_idle_end", idle, 1);

    check("ar_q_drained", ar_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
